// File: rtl/sigma_pkg.sv
// Shared definitions for the sigma_cpu core: opcodes, sequencer states,
// condition-code bit indices and instruction field positions.
package sigma_pkg;

    localparam logic [6:0] OP_AI   = 7'h20;
    localparam logic [6:0] OP_LI   = 7'h22;
    localparam logic [6:0] OP_WAIT = 7'h2E;
    localparam logic [6:0] OP_AW   = 7'h30;
    localparam logic [6:0] OP_CW   = 7'h31;
    localparam logic [6:0] OP_LW   = 7'h32;
    localparam logic [6:0] OP_BCR  = 7'h68;
    localparam logic [6:0] OP_BCS  = 7'h69;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_INDIRECT = 3'd1,
        ST_OPERAND  = 3'd2,
        ST_EXEC     = 3'd3,
        ST_HALT     = 3'd4
    } state_t;

    // CC is held as [3:0] with CC1 in the MSB so it lines up with the
    // 4-bit R mask used by BCR/BCS.
    localparam int CC1 = 3;
    localparam int CC2 = 2;
    localparam int CC3 = 1;
    localparam int CC4 = 0;

    // Field positions in LSB-0 numbering (Sigma bit n maps to bit 31-n).
    localparam int F_I      = 31;
    localparam int F_OP_HI  = 30;
    localparam int F_OP_LO  = 24;
    localparam int F_R_HI   = 23;
    localparam int F_R_LO   = 20;
    localparam int F_X_HI   = 19;
    localparam int F_X_LO   = 17;
    localparam int F_REF_HI = 16;
    localparam int F_IMM_HI = 19;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_AW) || (op == OP_CW);
    endfunction

    function automatic logic is_imm_op(input logic [6:0] op);
        return (op == OP_LI) || (op == OP_AI);
    endfunction

    function automatic logic is_branch_op(input logic [6:0] op);
        return (op == OP_BCR) || (op == OP_BCS);
    endfunction

    function automatic logic is_impl_op(input logic [6:0] op);
        return is_mem_op(op) || is_imm_op(op) || is_branch_op(op) || (op == OP_WAIT);
    endfunction

endpackage

// File: rtl/sigma_regfile.sv
// 16x32 general register file: two combinational read ports (R and X),
// one synchronous write port, asynchronous clear on reset.
module sigma_regfile (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  r_idx,
    input  logic [2:0]  x_idx,
    output logic [31:0] r_val,
    output logic [31:0] x_val,
    input  logic        we,
    input  logic [3:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs [16];

    assign r_val = regs[r_idx];
    assign x_val = regs[{1'b0, x_idx}];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

endmodule

// File: rtl/sigma_cpu.sv
// Sigma-style 32-bit CPU core: FETCH/INDIRECT/OPERAND/EXEC/HALT sequencer
// over a read-only instruction subset. Optional trapping: SIGMA_TRAP_EN.
module sigma_cpu
    import sigma_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic [0:31]  data_in,
    output logic [15:31] address
);

    logic [31:0] p;
    logic [16:0] q;
    logic [31:0] c;
    logic [6:0]  o;
    logic [3:0]  cc;
    logic        ende;
    logic        trap;

    logic [3:0]  r_fld;
    logic [19:0] imm;
    logic [16:0] ea;
    state_t      state, state_next;

    logic [31:0] word;
    logic [6:0]  f_op;
    logic        f_i;
    logic [2:0]  f_x;
    logic [16:0] f_ref;
    logic [16:0] ea_fetch;

    logic [31:0] r_val, x_val;
    logic        we;
    logic [31:0] result;
    logic [3:0]  cc_next;
    logic        take;

    assign word  = data_in;
    assign f_op  = word[F_OP_HI:F_OP_LO];
    assign f_i   = word[F_I];
    assign f_x   = word[F_X_HI:F_X_LO];
    assign f_ref = word[F_REF_HI:0];

    // Indirect references use the raw reference field; indexing applies
    // only to direct references.
    assign ea_fetch = (f_i || (f_x == 3'd0)) ? f_ref : f_ref + x_val[16:0];

    sigma_regfile u_regfile (
        .clock (clock),
        .reset (reset),
        .r_idx (r_fld),
        .x_idx (f_x),
        .r_val (r_val),
        .x_val (x_val),
        .we    (we),
        .wa    (r_fld),
        .wd    (result)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH: begin
                if (is_imm_op(f_op) || (f_op == OP_WAIT) || !is_impl_op(f_op))
                    state_next = ST_EXEC;
                else if (f_i)
                    state_next = ST_INDIRECT;
                else if (is_mem_op(f_op))
                    state_next = ST_OPERAND;
                else
                    state_next = ST_EXEC;
            end
            ST_INDIRECT: state_next = is_mem_op(o) ? ST_OPERAND : ST_EXEC;
            ST_OPERAND:  state_next = ST_EXEC;
            ST_EXEC: begin
                if (o == OP_WAIT)
                    state_next = ST_HALT;
`ifdef SIGMA_TRAP_EN
                else if (!is_impl_op(o))
                    state_next = ST_HALT;
`endif
                else
                    state_next = ST_FETCH;
            end
            ST_HALT:     state_next = ST_HALT;
            default:     state_next = ST_FETCH;
        endcase
    end

    always_comb begin
        case (state)
            ST_INDIRECT, ST_OPERAND: address = ea;
            default:                 address = p[18:2];
        endcase
    end

    // Execute datapath: one adder serves AI and AW, CW uses signed compares.
    logic [31:0] sext;
    logic [31:0] opd;
    logic [32:0] sum;
    logic        ovf;

    always_comb begin
        sext    = {{12{imm[F_IMM_HI]}}, imm};
        opd     = is_imm_op(o) ? sext : c;
        sum     = {1'b0, r_val} + {1'b0, opd};
        ovf     = (r_val[31] == opd[31]) && (sum[31] != r_val[31]);
        result  = sum[31:0];
        we      = 1'b0;
        cc_next = cc;
        take    = 1'b0;
        case (o)
            OP_LI: result = sext;
            OP_LW: result = c;
            default: result = sum[31:0];
        endcase
        if (state == ST_EXEC) begin
            case (o)
                OP_LI, OP_LW: begin
                    we           = 1'b1;
                    cc_next[CC3] = !result[31] && (result != 32'd0);
                    cc_next[CC4] = result[31];
                end
                OP_AI, OP_AW: begin
                    we           = 1'b1;
                    cc_next[CC1] = sum[32];
                    cc_next[CC2] = ovf;
                    cc_next[CC3] = !result[31] && (result != 32'd0);
                    cc_next[CC4] = result[31];
                end
                OP_CW: begin
                    cc_next[CC1] = 1'b0;
                    cc_next[CC2] = 1'b0;
                    cc_next[CC3] = $signed(r_val) > $signed(c);
                    cc_next[CC4] = $signed(r_val) < $signed(c);
                end
                OP_BCR:  take = ((cc & r_fld) == 4'd0);
                OP_BCS:  take = ((cc & r_fld) != 4'd0);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_FETCH;
            p     <= '0;
            q     <= '0;
            c     <= '0;
            o     <= '0;
            cc    <= '0;
            r_fld <= '0;
            imm   <= '0;
            ea    <= '0;
            ende  <= 1'b0;
        end else begin
            state <= state_next;
            ende  <= (state_next == ST_EXEC);
            case (state)
                ST_FETCH: begin
                    c     <= word;
                    o     <= f_op;
                    r_fld <= word[F_R_HI:F_R_LO];
                    imm   <= word[F_IMM_HI:0];
                    ea    <= ea_fetch;
                    p     <= p + 32'd4;
                    q     <= q + 17'd1;
                end
                ST_INDIRECT: ea <= word[F_REF_HI:0];
                ST_OPERAND:  c  <= word;
                ST_EXEC: begin
                    cc <= cc_next;
                    if (take) begin
                        p <= {13'd0, ea, 2'b00};
                        q <= ea;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SIGMA_TRAP_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            trap <= 1'b0;
        else if ((state == ST_EXEC) && !is_impl_op(o))
            trap <= 1'b1;
    end
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_sigma_cpu.sv
// Directed bench for sigma_cpu: small programs in a combinational memory,
// checked at fixed cycle counts against hand-computed results.
module tb_sigma_cpu;
    import sigma_pkg::*;

    logic         clock;
    logic         reset;
    logic [0:31]  data_in;
    logic [15:31] address;

    logic [31:0] mem [256];
    int          errors;
    int          checks;
    int          ende_cnt;
    logic        log_en;
    logic [31:0] act_q [$];
    logic [31:0] exp_q [$];

    sigma_cpu dut (
        .clock   (clock),
        .reset   (reset),
        .data_in (data_in),
        .address (address)
    );

    assign data_in = mem[address[24:31]];

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    always @(negedge clock) begin
        if (reset && dut.ende) ende_cnt++;
        if (reset && log_en && dut.state == ST_FETCH) act_q.push_back(32'(address));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ende_cnt = 0;
        act_q.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        ende_cnt = 0;
        log_en = 1'b0;
        reset = 1'b0;
        clear_mem();
        #1;
        check("reset_address", 32'(address), 32'h0);
        check("reset_p", dut.p, 32'h0);
        check("reset_state", 32'(dut.state), 32'(ST_FETCH));

        // LI / WAIT
        clear_mem();
        mem[0] = 32'h22100005;
        mem[1] = 32'h2E000000;
        do_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("wait_exec_ende", 32'(dut.ende), 32'h1);
        @(posedge clock);
        #1;
        check("liw_o", 32'(dut.o), 32'h2E);
        check("liw_r1", dut.u_regfile.regs[1], 32'h5);
        check("liw_cc", 32'(dut.cc), 32'b0010);
        check("liw_word", (dut.p >> 2) - 1, 32'h1);
        check("liw_halt", 32'(dut.state), 32'(ST_HALT));
        run(4);
        check("liw_ende_count", ende_cnt, 2);
        check("liw_halt_addr", 32'(address), 32'h2);

        // AW with carry
        clear_mem();
        mem[0]    = 32'h22100005;
        mem[1]    = 32'h30100010;
        mem[2]    = 32'h2E000000;
        mem[8'h10] = 32'hFFFFFFFD;
        do_reset();
        run(10);
        check("aw_r1", dut.u_regfile.regs[1], 32'h2);
        check("aw_cc", 32'(dut.cc), 32'b1010);

        // BCR taken
        clear_mem();
        mem[0] = 32'h22200000;
        mem[1] = 32'h68300008;
        mem[8] = 32'h2E000000;
        exp_q.delete();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h8);
        do_reset();
        log_en = 1'b1;
        run(8);
        log_en = 1'b0;
        for (int i = 0; i < 3; i++)
            check("bcr_fetch_addr", (i < act_q.size()) ? act_q[i] : 32'hDEADBEEF, exp_q[i]);
        check("bcr_word", (dut.p >> 2) - 1, 32'h8);

        // BCR not taken: mask hits CC3 set by LI 5
        clear_mem();
        mem[0] = 32'h22100005;
        mem[1] = 32'h68200008;
        mem[2] = 32'h2E000000;
        mem[8] = 32'h2E000000;
        do_reset();
        run(8);
        check("bcr_nt_word", (dut.p >> 2) - 1, 32'h2);

        // CW: 5 < 7
        clear_mem();
        mem[0]     = 32'h22100005;
        mem[1]     = 32'h31100010;
        mem[2]     = 32'h2E000000;
        mem[8'h10] = 32'h00000007;
        do_reset();
        run(10);
        check("cw_cc", 32'(dut.cc), 32'b0001);
        check("cw_r1", dut.u_regfile.regs[1], 32'h5);

        // Indexed + indirect LW
        clear_mem();
        mem[0]     = 32'h22200004;
        mem[1]     = 32'hB2340010;
        mem[2]     = 32'h2E000000;
        mem[8'h10] = 32'h00000020;
        mem[8'h20] = 32'h12345678;
        do_reset();
        run(5);
        check("lwi_r3_early", dut.u_regfile.regs[3], 32'h0);
        check("lwi_state", 32'(dut.state), 32'(ST_EXEC));
        run(1);
        check("lwi_r3", dut.u_regfile.regs[3], 32'h12345678);

        // Unimplemented opcode
        clear_mem();
        mem[0] = 32'h7F000000;
        do_reset();
        @(posedge clock);
        @(negedge clock);
        check("unimpl_ende", 32'(dut.ende), 32'h1);
        run(1);
`ifdef SIGMA_TRAP_EN
        check("trap_flag", 32'(dut.trap), 32'h1);
        check("trap_word", 32'(dut.q) - 1, 32'h0);
        check("trap_halt", 32'(dut.state), 32'(ST_HALT));
`else
        check("nop_p", dut.p, 32'h4);
        check("nop_trap", 32'(dut.trap), 32'h0);
        check("nop_state", 32'(dut.state), 32'(ST_FETCH));
`endif

        // Reset during OPERAND of AW
        clear_mem();
        mem[0]     = 32'h22100005;
        mem[1]     = 32'h30100010;
        mem[2]     = 32'h2E000000;
        mem[8'h10] = 32'hFFFFFFFD;
        do_reset();
        run(3);
        check("rst_pre_state", 32'(dut.state), 32'(ST_OPERAND));
        check("rst_pre_addr", 32'(address), 32'h10);
        reset = 1'b0;
        #1;
        check("rst_addr", 32'(address), 32'h0);
        check("rst_r1", dut.u_regfile.regs[1], 32'h0);
        check("rst_cc", 32'(dut.cc), 32'h0);
        check("rst_p", dut.p, 32'h0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        run(10);
        check("rst_rerun_r1", dut.u_regfile.regs[1], 32'h2);
        check("rst_rerun_cc", 32'(dut.cc), 32'b1010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
